// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP control-word bit map, widths and opcodes
package sap_pkg;

    localparam int SAP_DATA_W = 8;
    localparam int SAP_ADDR_W = 4;
    localparam int CTRL_W     = 15;
    localparam int OPC_W      = 4;

    localparam int CB_PC_INC          = 14;
    localparam int CB_PC_EN           = 13;
    localparam int CB_PC_LOAD         = 12;
    localparam int CB_MAR_ADDR_LOAD_N = 11;
    localparam int CB_MAR_MEM_LOAD_N  = 10;
    localparam int CB_RAM_EN_N        = 9;
    localparam int CB_RAM_LOAD_N      = 8;
    localparam int CB_IR_LOAD_N       = 7;
    localparam int CB_IR_EN_N         = 6;
    localparam int CB_REGA_LOAD_N     = 5;
    localparam int CB_REGA_EN         = 4;
    localparam int CB_ADDER_SUB       = 3;
    localparam int CB_ALU_EN          = 2;
    localparam int CB_REGB_LOAD_N     = 1;
    localparam int CB_OUT_LOAD_N      = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

endpackage

// File: rtl/sap_ram.sv
// rtl/sap_ram.sv - async-read program/data RAM with two prioritised write ports
module sap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Port 0 suppresses port 1 entirely on a shared edge, regardless of address.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[addr0] <= wdata0;
        end else if (we1) begin
            mem[addr1] <= wdata1;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP W-bus datapath: bus mux, PC/MAR/MDR/IR/A/B/OUT, ALU, RAM
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              halt,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] out_val,
    output logic [DATA_W-1:0] bus,
    output logic              flag_c,
    output logic              flag_z,
    output logic              bus_err
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [4:0]        drv;
    logic              multi_drv;
    logic              ram_we;

    // Subtraction is A + ~B + 1, so carry out is the "no borrow" (A >= B) indicator.
    always_comb begin
        operand_b = ctrl[CB_ADDER_SUB] ? ~reg_b : reg_b;
        sum       = {1'b0, reg_a} + {1'b0, operand_b} + (DATA_W+1)'(ctrl[CB_ADDER_SUB]);
    end

    assign alu_res   = sum[DATA_W-1:0];
    assign alu_carry = sum[DATA_W];

    assign drv = {ctrl[CB_PC_EN], ~ctrl[CB_RAM_EN_N], ~ctrl[CB_IR_EN_N],
                  ctrl[CB_REGA_EN], ctrl[CB_ALU_EN]};
    assign multi_drv = (drv & (drv - 5'd1)) != 5'd0;

    always_comb begin
        bus = '0;
        if (drv[4]) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
        end else if (drv[3]) begin
            bus = ram_rdata;
        end else if (drv[2]) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
        end else if (drv[1]) begin
            bus = reg_a;
        end else if (drv[0]) begin
            bus = alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            mar     <= '0;
            mdr     <= '0;
            ir      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            out_r   <= '0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            bus_err <= 1'b0;
        end else if (!halt) begin
            if (ctrl[CB_PC_LOAD]) begin
                pc <= bus[ADDR_W-1:0];
            end else if (ctrl[CB_PC_INC]) begin
                pc <= pc + ADDR_W'(1);
            end
            if (!ctrl[CB_MAR_ADDR_LOAD_N]) mar   <= bus[ADDR_W-1:0];
            if (!ctrl[CB_MAR_MEM_LOAD_N])  mdr   <= bus;
            if (!ctrl[CB_IR_LOAD_N])       ir    <= bus;
            if (!ctrl[CB_REGA_LOAD_N])     reg_a <= bus;
            if (!ctrl[CB_REGB_LOAD_N])     reg_b <= bus;
            if (!ctrl[CB_OUT_LOAD_N])      out_r <= bus;
            if (ctrl[CB_ALU_EN]) begin
                flag_c <= alu_carry;
                flag_z <= (alu_res == '0);
            end
            if (multi_drv) bus_err <= 1'b1;
        end
    end

    assign ram_we = !rst && !halt && !ctrl[CB_RAM_LOAD_N];

    sap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we0    (prog_we && !rst),
        .addr0  (prog_addr),
        .wdata0 (prog_data),
        .we1    (ram_we),
        .addr1  (mar),
        .wdata1 (mdr),
        .raddr  (mar),
        .rdata  (ram_rdata)
    );

    assign opcode  = ir[DATA_W-1:DATA_W-4];
    assign out_val = out_r;

endmodule

// File: tb/tb_sap_datapath.sv
// tb/tb_sap_datapath.sv - directed scoreboard bench for sap_datapath
module tb_sap_datapath;
    import sap_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] ctrl;
    logic        halt;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [7:0]  out_val;
    logic [7:0]  bus;
    logic        flag_c;
    logic        flag_z;
    logic        bus_err;

    sap_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .halt      (halt),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .opcode    (opcode),
        .out_val   (out_val),
        .bus       (bus),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // One-hot "asserted" masks; active-low bits are inverted by NMASK on the way out.
    localparam logic [14:0] K_PC_INC     = 15'(1) << CB_PC_INC;
    localparam logic [14:0] K_PC_EN      = 15'(1) << CB_PC_EN;
    localparam logic [14:0] K_PC_LOAD    = 15'(1) << CB_PC_LOAD;
    localparam logic [14:0] K_MAR_ADDR   = 15'(1) << CB_MAR_ADDR_LOAD_N;
    localparam logic [14:0] K_MAR_MEM    = 15'(1) << CB_MAR_MEM_LOAD_N;
    localparam logic [14:0] K_RAM_EN     = 15'(1) << CB_RAM_EN_N;
    localparam logic [14:0] K_RAM_LOAD   = 15'(1) << CB_RAM_LOAD_N;
    localparam logic [14:0] K_IR_LOAD    = 15'(1) << CB_IR_LOAD_N;
    localparam logic [14:0] K_IR_EN      = 15'(1) << CB_IR_EN_N;
    localparam logic [14:0] K_REGA_LOAD  = 15'(1) << CB_REGA_LOAD_N;
    localparam logic [14:0] K_REGA_EN    = 15'(1) << CB_REGA_EN;
    localparam logic [14:0] K_SUB        = 15'(1) << CB_ADDER_SUB;
    localparam logic [14:0] K_ALU_EN     = 15'(1) << CB_ALU_EN;
    localparam logic [14:0] K_REGB_LOAD  = 15'(1) << CB_REGB_LOAD_N;
    localparam logic [14:0] K_OUT_LOAD   = 15'(1) << CB_OUT_LOAD_N;
    localparam logic [14:0] NMASK = K_MAR_ADDR | K_MAR_MEM | K_RAM_EN | K_RAM_LOAD | K_IR_LOAD
                                  | K_IR_EN | K_REGA_LOAD | K_REGB_LOAD | K_OUT_LOAD;

    localparam int S_BUS = 0, S_OUT = 1, S_OPC = 2, S_C = 3, S_Z = 4, S_ERR = 5;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] mar_m;

    function automatic logic [7:0] observe(int sel);
        case (sel)
            S_BUS:   return bus;
            S_OUT:   return out_val;
            S_OPC:   return {4'h0, opcode};
            S_C:     return {7'h0, flag_c};
            S_Z:     return {7'h0, flag_z};
            default: return {7'h0, bus_err};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [7:0] e);
        exp_t t;
        t.tag = tag;
        t.sel = sel;
        t.exp = e;
        sbq.push_back(t);
    endtask

    task automatic check_now();
        exp_t       t;
        logic [7:0] o;
        while (sbq.size() > 0) begin
            t = sbq.pop_front();
            o = observe(t.sel);
            checks++;
            assert (o === t.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t.tag, o, t.exp);
            end
        end
    endtask

    task automatic expect_now(input int sel, input logic [7:0] e, input string tag);
        push(tag, sel, e);
        check_now();
    endtask

    task automatic drive(input logic [14:0] on);
        ctrl = on ^ NMASK;
    endtask

    task automatic cyc(input logic [14:0] on);
        drive(on);
        @(posedge clk);
        #1;
        drive(15'h0);
    endtask

    task automatic peek(input logic [14:0] on, input logic [7:0] e, input string tag);
        push(tag, S_BUS, e);
        drive(on);
        #1;
        check_now();
        drive(15'h0);
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
    endtask

    // Place a value in RAM at the current MAR, then put it on the bus into the requested loads.
    task automatic load_val(input logic [7:0] v, input logic [14:0] on);
        prog(mar_m, v);
        cyc(K_RAM_EN | on);
    endtask

    task automatic set_mar(input logic [3:0] a);
        prog(mar_m, {4'h0, a});
        cyc(K_RAM_EN | K_MAR_ADDR);
        mar_m = a;
    endtask

    initial begin
        ctrl      = NMASK;
        rst       = 1'b1;
        halt      = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        mar_m = 4'h0;

        // Preload everything, then a single reset edge must clear it but keep RAM.
        prog(4'h3, 8'h77);
        load_val(8'h55, K_REGA_LOAD | K_REGB_LOAD | K_OUT_LOAD | K_IR_LOAD);
        cyc(K_ALU_EN | K_SUB);
        cyc(K_PC_EN | K_REGA_EN);
        expect_now(S_OUT, 8'h55, "pre_out");
        expect_now(S_OPC, 8'h05, "pre_opcode");
        expect_now(S_C,   8'h01, "pre_c");
        expect_now(S_Z,   8'h01, "pre_z");
        expect_now(S_ERR, 8'h01, "pre_err");
        rst = 1'b1;
        cyc(15'h0);
        rst = 1'b0;
        mar_m = 4'h0;
        expect_now(S_OUT, 8'h00, "rst_out");
        expect_now(S_OPC, 8'h00, "rst_opcode");
        expect_now(S_C,   8'h00, "rst_c");
        expect_now(S_Z,   8'h00, "rst_z");
        expect_now(S_ERR, 8'h00, "rst_err");
        expect_now(S_BUS, 8'h00, "rst_idle_bus");
        peek(K_REGA_EN, 8'h00, "rst_a");
        peek(K_ALU_EN,  8'h00, "rst_alu");
        peek(K_PC_EN,   8'h00, "rst_pc");
        set_mar(4'h3);
        peek(K_RAM_EN,  8'h77, "rst_ram_keep");

        // Fetch
        prog(4'h0, 8'h2E);
        cyc(K_PC_EN | K_MAR_ADDR);
        mar_m = 4'h0;
        cyc(K_RAM_EN | K_IR_LOAD | K_PC_INC);
        expect_now(S_OPC, 8'h02, "fetch_opcode");
        peek(K_IR_EN,  8'h0E, "fetch_ir_low");
        peek(K_PC_EN,  8'h01, "fetch_pc");
        peek(K_RAM_EN, 8'h2E, "fetch_mar0");

        // ALU
        load_val(8'h0F, K_REGA_LOAD);
        load_val(8'h01, K_REGB_LOAD);
        peek(K_ALU_EN, 8'h10, "add_bus");
        cyc(K_ALU_EN | K_REGA_LOAD);
        peek(K_REGA_EN, 8'h10, "add_a");
        expect_now(S_C, 8'h00, "add_c");
        expect_now(S_Z, 8'h00, "add_z");
        load_val(8'h05, K_REGA_LOAD);
        load_val(8'h05, K_REGB_LOAD);
        cyc(K_ALU_EN | K_SUB | K_REGA_LOAD);
        peek(K_REGA_EN, 8'h00, "sub_eq_a");
        expect_now(S_C, 8'h01, "sub_eq_c");
        expect_now(S_Z, 8'h01, "sub_eq_z");
        load_val(8'hFF, K_REGA_LOAD);
        load_val(8'h01, K_REGB_LOAD);
        cyc(K_ALU_EN | K_REGA_LOAD);
        peek(K_REGA_EN, 8'h00, "add_ovf_a");
        expect_now(S_C, 8'h01, "add_ovf_c");
        expect_now(S_Z, 8'h01, "add_ovf_z");
        load_val(8'h03, K_REGA_LOAD);
        expect_now(S_C, 8'h01, "flag_hold_c");
        expect_now(S_Z, 8'h01, "flag_hold_z");
        cyc(K_ALU_EN | K_SUB | K_OUT_LOAD);
        expect_now(S_OUT, 8'h02, "sub_out");
        expect_now(S_C,   8'h01, "sub_c");
        expect_now(S_Z,   8'h00, "sub_z");
        load_val(8'h01, K_REGA_LOAD);
        load_val(8'h03, K_REGB_LOAD);
        cyc(K_ALU_EN | K_SUB | K_OUT_LOAD);
        expect_now(S_OUT, 8'hFE, "borrow_out");
        expect_now(S_C,   8'h00, "borrow_c");
        expect_now(S_Z,   8'h00, "borrow_z");

        // STA path
        set_mar(4'h8);
        load_val(8'hA5, K_MAR_MEM);
        set_mar(4'h9);
        prog(4'h9, 8'h00);
        cyc(K_RAM_LOAD);
        peek(K_RAM_EN, 8'hA5, "sta_read");
        prog_we   = 1'b1;
        prog_addr = 4'h9;
        prog_data = 8'h3C;
        drive(K_RAM_LOAD);
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        drive(15'h0);
        peek(K_RAM_EN, 8'h3C, "sta_prog_wins");
        cyc(K_PC_EN | K_MAR_ADDR | K_RAM_LOAD);
        mar_m = 4'h1;
        set_mar(4'h9);
        peek(K_RAM_EN, 8'hA5, "sta_old_mar");

        // PC wrap and load-over-increment priority
        load_val(8'h0F, K_PC_LOAD);
        peek(K_PC_EN, 8'h0F, "pc_load");
        cyc(K_PC_INC);
        peek(K_PC_EN, 8'h00, "pc_wrap");
        load_val(8'h07, K_PC_LOAD | K_PC_INC);
        peek(K_PC_EN, 8'h07, "pc_prio");

        // Bus conflict
        peek(K_PC_EN | K_REGA_EN, 8'h07, "conflict_bus");
        expect_now(S_ERR, 8'h00, "err_before_edge");
        cyc(K_PC_EN | K_REGA_EN);
        expect_now(S_ERR, 8'h01, "err_set");
        cyc(15'h0);
        cyc(15'h0);
        expect_now(S_ERR, 8'h01, "err_sticky");
        peek(K_RAM_EN | K_ALU_EN, 8'h07, "conflict_ram_alu");

        // Halt freezes state but not the bus or prog port
        halt = 1'b1;
        load_val(8'h99, K_OUT_LOAD | K_REGA_LOAD);
        expect_now(S_OUT, 8'hFE, "halt_out");
        peek(K_RAM_EN, 8'h99, "halt_bus");
        cyc(K_PC_INC);
        halt = 1'b0;
        peek(K_PC_EN, 8'h07, "halt_pc");
        cyc(K_RAM_EN | K_OUT_LOAD);
        expect_now(S_OUT, 8'h99, "unhalt_out");

        // Reset beats a same-edge program write
        rst       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'h9;
        prog_data = 8'h11;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        rst     = 1'b0;
        mar_m   = 4'h0;
        expect_now(S_ERR, 8'h00, "rst_clears_err");
        set_mar(4'h9);
        peek(K_RAM_EN, 8'h99, "rst_beats_prog");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
